pulse_scheduler: RTL and testbench
==================================

PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

Interface
REQ-001 Parameter DIV_W, default 4: width of the half-period field, in clock cycles.
REQ-002 Parameter CNT_W, default 4: width of the burst-length field, in pulses.
REQ-003 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port req0 / req1, input, 1 each: level burst request from requester 0 / 1.
REQ-006 Port div0 / div1, input, DIV_W each: half-period requested by requester 0 / 1; value 0 SHALL be treated as 1.
REQ-007 Port cnt0 / cnt1, input, CNT_W each: number of pulses requested by requester 0 / 1.
REQ-008 Port gnt0 / gnt1, output, 1 each: requester 0 / 1 owns the pulse resource; at most one is high at a time.
REQ-009 Port busy, output, 1: high when the state is not IDLE.
REQ-010 Port pulse_out, output, 1: shared pulse waveform.
REQ-011 Port done0 / done1, output, 1 each: one-cycle burst-complete strobe for requester 0 / 1.

Function
REQ-012 The FSM SHALL have the states IDLE, HIGH, LOW and DONE; all outputs SHALL be registered.
REQ-013 In IDLE, arbitration SHALL run only when req0 or req1 is high; requests are sampled only in IDLE.
- Only one request high: that requester wins.
- Both high: the requester not served last wins (round-robin).
- After reset, requester 0 has priority.
REQ-014 On the winning edge the block SHALL:
- latch the winner's div (0 mapped to 1) and cnt;
- assert the matching gnt;
- enter HIGH if cnt is nonzero, or DONE if cnt is 0 (no pulse emitted).
REQ-015 pulse_out SHALL be 1 in HIGH and 0 in every other state.
REQ-016 HIGH and LOW SHALL each last exactly div cycles, so one pulse period is 2*div cycles.
REQ-017 At the end of each LOW, the remaining count SHALL decrement:
- if it reaches 0, go to DONE;
- otherwise go back to HIGH.
REQ-018 DONE SHALL last one cycle, assert done of the owner and keep gnt high.
REQ-019 On the next cycle the block SHALL return to IDLE, deassert gnt and update the last-served pointer.
REQ-020 Deasserting req, or changing div/cnt, during a burst SHALL have no effect on that burst.
REQ-021 A request still pending in IDLE SHALL be granted on the first IDLE edge; IDLE therefore lasts at least one cycle between bursts.
REQ-022 Latency:
- Request seen in IDLE at edge t: gnt and pulse_out high from cycle t+1.
- Burst of cnt pulses: busy for 2*div*cnt + 1 cycles.
REQ-023 Maximum values (div = 2^DIV_W - 1, cnt = 2^CNT_W - 1) SHALL run without counter wrap; the counters SHALL be wide enough to hold the maximum values.

Reset
REQ-024 reset high at a rising edge SHALL force, irrespective of current state and mid-burst:
- state IDLE;
- gnt0 = gnt1 = 0, busy = 0, pulse_out = 0, done0 = done1 = 0;
- last-served pointer to requester 1, so requester 0 wins the first tie;
- internal counters to 0.
REQ-025 A burst interrupted by reset SHALL NOT produce a done strobe.
REQ-026 The first arbitration SHALL occur on the first edge with reset low.

Structure
REQ-027 A shared package pulse_sched_pkg SHALL hold:
- the FSM state encoding (IDLE, HIGH, LOW, DONE);
- default DIV_W and CNT_W values.
REQ-028 One sub-module, pulse_timer, SHALL implement the half-period down-counter, with:
- inputs: load, load value, enable;
- output: a one-cycle expire flag.
REQ-029 Arbitration, the pulse counter and the FSM SHALL reside in pulse_scheduler, targeting 150-300 lines of RTL.

Verification
REQ-030 Single burst: req0 = 1, div0 = 3, cnt0 = 2 → gnt0 high for 13 cycles, pulse_out pattern 111000111000 then 0, done0 high on cycle 13 only.
REQ-031 Tie: req0 = req1 = 1 after reset, div = 1, cnt = 1 → requester 0 served first, then requester 1 after one IDLE cycle, then requester 0 again; gnt0 and gnt1 never high together.
REQ-032 Zero cases:
- cnt1 = 0 → gnt1 high 1 cycle with done1, pulse_out stays 0;
- div0 = 0, cnt0 = 3 → pulse_out alternates 1,0 for 6 cycles.
REQ-033 Reset mid-burst: reset asserted during the second HIGH of a div = 2, cnt = 4 burst → next cycle all outputs 0, no done; after release with req0 high, a fresh burst starts with requester 0.
REQ-034 Input changes mid-burst: req0 dropped and div0/cnt0 changed during a div = 2, cnt = 3 burst → the burst still emits exactly 3 pulses of period 4.
REQ-035 Max values: DIV_W = 4, CNT_W = 4, div = 15, cnt = 15 → busy for 451 cycles, exactly 15 pulses, one done strobe.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse scheduler: FSM state encoding and default field widths.
package pulse_sched_pkg;

  localparam int DEF_DIV_W = 4;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_timer.sv
// Half-period down-counter: load sets the count, enable decrements it.
// expire is high for one cycle while the final count of a half-period is live.
module pulse_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] rem;

  always_ff @(posedge clock) begin
    if (reset) begin
      rem <= '0;
    end else if (load) begin
      rem <= load_val;
    end else if (en && (rem != '0)) begin
      rem <= rem - W'(1);
    end
  end

  // The caller reloads on expire, so expire must not depend on load.
  assign expire = en && (rem == W'(1));

endmodule

// File: rtl/pulse_scheduler.sv
// Two-requester round-robin burst scheduler driving one shared pulse waveform.
// Grant and first pulse appear the cycle after a request is seen in IDLE; a burst holds the resource until done.
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [DIV_W-1:0] div0,
  input  logic [DIV_W-1:0] div1,
  input  logic [CNT_W-1:0] cnt0,
  input  logic [CNT_W-1:0] cnt1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             pulse_out,
  output logic             done0,
  output logic             done1
);

  state_t             state;
  logic [DIV_W-1:0]   div_q;
  logic [CNT_W-1:0]   pcnt;
  logic               owner;
  logic               last;

  logic               win0;
  logic               win1;
  logic [CNT_W-1:0]   win_cnt;
  logic               load;
  logic [DIV_W-1:0]   load_val;
  logic               en;
  logic               expire;

  function automatic logic [DIV_W-1:0] fix_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  // Exactly one winner at most: on a tie, last selects whichever side was not served last.
  always_comb begin
    win0     = req0 && (!req1 || last);
    win1     = req1 && (!req0 || !last);
    win_cnt  = win1 ? cnt1 : cnt0;
    load     = 1'b0;
    load_val = div_q;
    en       = (state == HIGH) || (state == LOW);
    case (state)
      IDLE: begin
        if (win0 || win1) begin
          load     = 1'b1;
          load_val = win1 ? fix_div(div1) : fix_div(div0);
        end
      end
      HIGH: begin
        if (expire) load = 1'b1;
      end
      LOW: begin
        if (expire && (pcnt != CNT_W'(1))) load = 1'b1;
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  pulse_timer #(
    .W(DIV_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .en      (en),
    .expire  (expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      busy      <= 1'b0;
      pulse_out <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      last      <= 1'b1;
      owner     <= 1'b0;
      div_q     <= '0;
      pcnt      <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (win0 || win1) begin
            owner <= win1;
            gnt0  <= win0;
            gnt1  <= win1;
            busy  <= 1'b1;
            div_q <= load_val;
            pcnt  <= win_cnt;
            if (win_cnt != '0) begin
              state     <= HIGH;
              pulse_out <= 1'b1;
            end else begin
              state <= DONE;
              done0 <= win0;
              done1 <= win1;
            end
          end
        end
        HIGH: begin
          if (expire) begin
            state     <= LOW;
            pulse_out <= 1'b0;
          end
        end
        LOW: begin
          if (expire) begin
            if (pcnt == CNT_W'(1)) begin
              state <= DONE;
              pcnt  <= '0;
              done0 <= !owner;
              done1 <= owner;
            end else begin
              state     <= HIGH;
              pcnt      <= pcnt - CNT_W'(1);
              pulse_out <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
          last  <= owner;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: cycle-by-cycle vector table plus burst-measuring sequences.
module tb_pulse_scheduler;

  logic       clock;
  logic       reset;
  logic       req0, req1;
  logic [3:0] div0, div1, cnt0, cnt1;
  logic       gnt0, gnt1, busy, pulse_out, done0, done1;

  int checks = 0;
  int errors = 0;

  pulse_scheduler #(.DIV_W(4), .CNT_W(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .div0     (div0),
    .div1     (div1),
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .busy     (busy),
    .pulse_out(pulse_out),
    .done0    (done0),
    .done1    (done1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected outputs packed as {gnt0, gnt1, busy, pulse_out, done0, done1}.
  typedef struct {
    logic       rst;
    logic       r0;
    logic       r1;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] c0;
    logic [3:0] c1;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic r0, input logic r1,
                     input logic [3:0] d0, input logic [3:0] d1,
                     input logic [3:0] c0, input logic [3:0] c1,
                     input logic [5:0] exp);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1;
    v.d0 = d0; v.d1 = d1; v.c0 = c0; v.c1 = c1;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_burst(input string name, input int exp_pulses, input int exp_half,
                           input int exp_busy, input logic mutate);
    int   busy_cyc = 0;
    int   pulses   = 0;
    int   done_cnt = 0;
    int   done_at  = -1;
    int   run      = 0;
    int   bad_run  = 0;
    int   bad_gnt  = 0;
    logic prev     = 1'b0;
    @(posedge clock); #1;
    while (busy && busy_cyc < 1000) begin
      busy_cyc++;
      if (busy_cyc == 1) begin
        req0 = 1'b0;
        if (mutate) begin
          div0 = 4'd7;
          cnt0 = 4'd9;
        end
      end
      if (pulse_out && !prev) pulses++;
      if (pulse_out == prev) begin
        run++;
      end else begin
        if (busy_cyc > 1 && run != exp_half) bad_run++;
        run = 1;
      end
      if (done0 || done1) begin
        done_cnt++;
        done_at = busy_cyc;
      end
      if (!gnt0 || gnt1) bad_gnt++;
      prev = pulse_out;
      @(posedge clock); #1;
    end
    check({name, "_busy_cycles"}, busy_cyc, exp_busy);
    check({name, "_pulses"}, pulses, exp_pulses);
    check({name, "_bad_half_periods"}, bad_run, 0);
    check({name, "_done_strobes"}, done_cnt, 1);
    check({name, "_done_cycle"}, done_at, exp_busy);
    check({name, "_bad_grant_cycles"}, bad_gnt, 0);
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    div0 = '0; div1 = '0; cnt0 = '0; cnt1 = '0;

    // Reset state
    add(1, 0, 0, 0, 0, 0, 0, 6'b000000);
    add(1, 0, 0, 0, 0, 0, 0, 6'b000000);

    // Single burst div=3 cnt=2: 111000111000 then done
    add(0, 1, 0, 3, 0, 2, 0, 6'b101100);
    for (int i = 0; i < 2; i++) add(0, 0, 0, 3, 0, 2, 0, 6'b101100);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 3, 0, 2, 0, 6'b101000);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 3, 0, 2, 0, 6'b101100);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 3, 0, 2, 0, 6'b101000);
    add(0, 0, 0, 3, 0, 2, 0, 6'b101010);
    add(0, 0, 0, 3, 0, 2, 0, 6'b000000);

    // Tie after reset: 0, idle, 1, idle, 0
    add(1, 1, 1, 1, 1, 1, 1, 6'b000000);
    add(0, 1, 1, 1, 1, 1, 1, 6'b101100);
    add(0, 1, 1, 1, 1, 1, 1, 6'b101000);
    add(0, 1, 1, 1, 1, 1, 1, 6'b101010);
    add(0, 1, 1, 1, 1, 1, 1, 6'b000000);
    add(0, 1, 1, 1, 1, 1, 1, 6'b011100);
    add(0, 1, 1, 1, 1, 1, 1, 6'b011000);
    add(0, 1, 1, 1, 1, 1, 1, 6'b011001);
    add(0, 1, 1, 1, 1, 1, 1, 6'b000000);
    add(0, 1, 1, 1, 1, 1, 1, 6'b101100);
    add(1, 1, 1, 1, 1, 1, 1, 6'b000000);

    // cnt1 = 0: one-cycle grant with done, no pulse
    add(0, 0, 1, 0, 5, 0, 0, 6'b011001);
    add(0, 0, 0, 0, 5, 0, 0, 6'b000000);
    add(0, 0, 0, 0, 5, 0, 0, 6'b000000);

    // div0 = 0 treated as 1, cnt0 = 3
    add(0, 1, 0, 0, 0, 3, 0, 6'b101100);
    add(0, 0, 0, 0, 0, 3, 0, 6'b101000);
    add(0, 0, 0, 0, 0, 3, 0, 6'b101100);
    add(0, 0, 0, 0, 0, 3, 0, 6'b101000);
    add(0, 0, 0, 0, 0, 3, 0, 6'b101100);
    add(0, 0, 0, 0, 0, 3, 0, 6'b101000);
    add(0, 0, 0, 0, 0, 3, 0, 6'b101010);
    add(0, 0, 0, 0, 0, 3, 0, 6'b000000);

    // Reset during the second HIGH of div=2 cnt=4, then a fresh burst
    add(1, 0, 0, 0, 0, 0, 0, 6'b000000);
    add(0, 1, 0, 2, 0, 4, 0, 6'b101100);
    add(0, 1, 0, 2, 0, 4, 0, 6'b101100);
    add(0, 1, 0, 2, 0, 4, 0, 6'b101000);
    add(0, 1, 0, 2, 0, 4, 0, 6'b101000);
    add(0, 1, 0, 2, 0, 4, 0, 6'b101100);
    add(1, 1, 0, 2, 0, 4, 0, 6'b000000);
    add(0, 1, 0, 2, 0, 4, 0, 6'b101100);
    add(0, 1, 0, 2, 0, 4, 0, 6'b101100);
    add(0, 1, 0, 2, 0, 4, 0, 6'b101000);
    add(1, 0, 0, 0, 0, 0, 0, 6'b000000);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      req0  = vecs[i].r0;
      req1  = vecs[i].r1;
      div0  = vecs[i].d0;
      div1  = vecs[i].d1;
      cnt0  = vecs[i].c0;
      cnt1  = vecs[i].c1;
      @(posedge clock); #1;
      check($sformatf("vec%0d", i), int'({gnt0, gnt1, busy, pulse_out, done0, done1}),
            int'(vecs[i].exp));
    end

    // Inputs changed mid-burst must not disturb a div=2 cnt=3 burst
    reset = 1'b0;
    req1  = 1'b0;
    req0  = 1'b1; div0 = 4'd2; cnt0 = 4'd3;
    run_burst("midchange", 3, 2, 13, 1'b1);

    // Maximum field values
    @(posedge clock); #1;
    req0 = 1'b1; div0 = 4'd15; cnt0 = 4'd15;
    run_burst("maxvals", 15, 15, 451, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
